// File: rtl/wb_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_byte_master
// Brief    : Byte-stream command decoder that runs single 32-bit Wishbone
//            read/write cycles and returns the result as reply bytes.
// Revision : 1.0
// ============================================================================
module wb_byte_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  rx_data,
    input  logic        rx_valid,

    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_busy,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,

    output logic        busy
);

    localparam int               c_TO_W     = $clog2(TIMEOUT) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);
    localparam logic [7:0]       c_CMD_WR   = 8'h57;
    localparam logic [7:0]       c_CMD_RD   = 8'h52;
    localparam logic [7:0]       c_BYTE_OK  = 8'h4B;
    localparam logic [7:0]       c_BYTE_ERR = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic [1:0]          r_cnt_q,     w_cnt_d;
    logic [c_TO_W-1:0]   r_to_q,      w_to_d;
    logic [31:0]         r_adr_q,     w_adr_d;
    logic [31:0]         r_dat_q,     w_dat_d;
    logic [31:0]         r_rd_q,      w_rd_d;
    logic                r_we_q,      w_we_d;
    logic                r_cyc_q,     w_cyc_d;
    logic                r_err_q,     w_err_d;
    logic [7:0]          r_tx_data_q, w_tx_data_d;
    logic                r_tx_valid_q, w_tx_valid_d;
    logic                r_busy_q,    w_busy_d;
    logic                w_last_byte;

    // Reply byte idx of a finished transfer: one status byte for writes and
    // timeouts, otherwise the read word MSB first.
    function automatic logic [7:0] f_reply(input logic        we,
                                           input logic        err,
                                           input logic [31:0] data,
                                           input logic [1:0]  idx);
        logic [7:0] res;
        if (err) begin
            res = c_BYTE_ERR;
        end else if (we) begin
            res = c_BYTE_OK;
        end else begin
            case (idx)
                2'd0:    res = data[31:24];
                2'd1:    res = data[23:16];
                2'd2:    res = data[15:8];
                default: res = data[7:0];
            endcase
        end
        return res;
    endfunction

    assign w_last_byte = r_err_q || r_we_q || (r_cnt_q == 2'd3);

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_to_d       = r_to_q;
        w_adr_d      = r_adr_q;
        w_dat_d      = r_dat_q;
        w_rd_d       = r_rd_q;
        w_we_d       = r_we_q;
        w_cyc_d      = r_cyc_q;
        w_err_d      = r_err_q;
        w_tx_data_d  = r_tx_data_q;
        w_tx_valid_d = r_tx_valid_q;

        case (r_state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == c_CMD_WR)) begin
                    w_state_d = ST_ADDR;
                    w_we_d    = 1'b1;
                    w_cnt_d   = 2'd0;
                end else if (rx_valid && (rx_data == c_CMD_RD)) begin
                    w_state_d = ST_ADDR;
                    w_we_d    = 1'b0;
                    w_cnt_d   = 2'd0;
                end
            end

            ST_ADDR: begin
                if (rx_valid) begin
                    w_adr_d = {r_adr_q[23:0], rx_data};
                    if (r_cnt_q == 2'd3) begin
                        w_cnt_d = 2'd0;
                        if (r_we_q) begin
                            w_state_d = ST_DATA;
                        end else begin
                            w_state_d = ST_BUS;
                            w_cyc_d   = 1'b1;
                            w_to_d    = '0;
                        end
                    end else begin
                        w_cnt_d = r_cnt_q + 2'd1;
                    end
                end
            end

            ST_DATA: begin
                if (rx_valid) begin
                    w_dat_d = {r_dat_q[23:0], rx_data};
                    if (r_cnt_q == 2'd3) begin
                        w_cnt_d   = 2'd0;
                        w_state_d = ST_BUS;
                        w_cyc_d   = 1'b1;
                        w_to_d    = '0;
                    end else begin
                        w_cnt_d = r_cnt_q + 2'd1;
                    end
                end
            end

            ST_BUS: begin
                // An ack on the last allowed cycle still counts as success.
                if (wb_ack_i) begin
                    w_cyc_d      = 1'b0;
                    w_rd_d       = wb_dat_i;
                    w_err_d      = 1'b0;
                    w_state_d    = ST_RESP;
                    w_cnt_d      = 2'd0;
                    w_tx_valid_d = 1'b1;
                    w_tx_data_d  = f_reply(r_we_q, 1'b0, wb_dat_i, 2'd0);
                end else if (r_to_q == c_TO_LAST) begin
                    w_cyc_d      = 1'b0;
                    w_err_d      = 1'b1;
                    w_state_d    = ST_RESP;
                    w_cnt_d      = 2'd0;
                    w_tx_valid_d = 1'b1;
                    w_tx_data_d  = c_BYTE_ERR;
                end else begin
                    w_to_d = r_to_q + c_TO_ONE;
                end
            end

            ST_RESP: begin
                // tx_valid drops for a cycle after every accepted byte.
                if (r_tx_valid_q) begin
                    if (!tx_busy) begin
                        w_tx_valid_d = 1'b0;
                        if (w_last_byte) begin
                            w_state_d = ST_IDLE;
                            w_cnt_d   = 2'd0;
                        end else begin
                            w_cnt_d = r_cnt_q + 2'd1;
                        end
                    end
                end else begin
                    w_tx_valid_d = 1'b1;
                    w_tx_data_d  = f_reply(r_we_q, r_err_q, r_rd_q, r_cnt_q);
                end
            end

            default: begin
                w_state_d    = ST_IDLE;
                w_cnt_d      = 2'd0;
                w_cyc_d      = 1'b0;
                w_tx_valid_d = 1'b0;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= 2'd0;
            r_to_q       <= '0;
            r_adr_q      <= 32'd0;
            r_dat_q      <= 32'd0;
            r_rd_q       <= 32'd0;
            r_we_q       <= 1'b0;
            r_cyc_q      <= 1'b0;
            r_err_q      <= 1'b0;
            r_tx_data_q  <= 8'd0;
            r_tx_valid_q <= 1'b0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_to_q       <= w_to_d;
            r_adr_q      <= w_adr_d;
            r_dat_q      <= w_dat_d;
            r_rd_q       <= w_rd_d;
            r_we_q       <= w_we_d;
            r_cyc_q      <= w_cyc_d;
            r_err_q      <= w_err_d;
            r_tx_data_q  <= w_tx_data_d;
            r_tx_valid_q <= w_tx_valid_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign tx_data  = r_tx_data_q;
    assign tx_valid = r_tx_valid_q;
    assign wb_adr_o = r_adr_q;
    assign wb_dat_o = r_dat_q;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = r_we_q;
    assign wb_cyc_o = r_cyc_q;
    assign wb_stb_o = r_cyc_q;
    assign busy     = r_busy_q;

endmodule
`default_nettype wire
